// File: rtl/cpld_spi_pkg.sv
// cpld_spi_pkg
// Shared constants for the CPLD SPI responder: register addresses, FSM state
// encodings, frame geometry, fixed byte values and the read-data multiplexer.
// No ports (package).

package cpld_spi_pkg;

    // Fixed byte values
    localparam logic [7:0] ID_VALUE   = 8'hC5;
    localparam logic [7:0] CTRL_RESET = 8'h00;
    localparam logic [7:0] SYNC_BYTE  = 8'h5A;

    // Register map
    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_STAT_LO = 3'd1;
    localparam logic [2:0] ADDR_STAT_HI = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_SCRATCH = 3'd4;
    localparam logic [2:0] ADDR_STROBE  = 3'd5;

    // Frame geometry
    localparam int unsigned FRAME_BITS = 16;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t StIdle = 2'd0;
    localparam state_t StCmd  = 2'd1;
    localparam state_t StData = 2'd2;
    localparam state_t StDone = 2'd3;

    // Read data for a given address. The strobe address and unmapped
    // addresses read as zero.
    function automatic logic [7:0] read_mux(
        input logic [2:0]  addr,
        input logic [15:0] status,
        input logic [7:0]  ctrl,
        input logic [7:0]  scratch
    );
        logic [7:0] value;
        value = 8'h00;
        case (addr)
            ADDR_ID:      value = ID_VALUE;
            ADDR_STAT_LO: value = status[7:0];
            ADDR_STAT_HI: value = status[15:8];
            ADDR_CTRL:    value = ctrl;
            ADDR_SCRATCH: value = scratch;
            default:      value = 8'h00;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
// Two-flop synchronizer for one asynchronous pin followed by a registered copy
// used for edge detection. The flops are not reset: they simply track the pin,
// and any edge seen while the parent is in reset is discarded there.
//
// Ports:
//   clk    in   sampling clock
//   din    in   asynchronous pin
//   level  out  synchronized level
//   rise   out  one-cycle pulse on a synchronized 0->1 transition
//   fall   out  one-cycle pulse on a synchronized 1->0 transition

module spi_sync_edge (
    input  logic clk,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        meta <= din;
        sync <= meta;
        prev <= sync;
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/cpld_spi_responder.sv
// cpld_spi_responder
// SPI mode-0 slave register file. A 16-bit frame carries a command byte
// ([7]=write, [2:0]=address) followed by a data byte. SCK, MOSI and CS are
// oversampled on sysclk through spi_sync_edge instances.
//
// Optional feature macro: CPLD_SPI_STROBE_EN enables the write-pulse register
// at address 5; without it strobe_out is tied low.
//
// Ports:
//   sysclk      in   internal oscillator clock
//   reset       in   synchronous active-high reset
//   spi_clk     in   SCK from host (asynchronous)
//   spi_mosi    in   MOSI (asynchronous)
//   spi_cs_INV  in   chip select, active low (asynchronous)
//   spi_miso    out  MISO, 0 while not actively shifting
//   status_in   in   live status bits, read at addresses 1 and 2
//   ctrl_out    out  control register
//   strobe_out  out  one-cycle write pulses
//   busy        out  high between CS-low and CS-high detection

module cpld_spi_responder
    import cpld_spi_pkg::*;
(
    input  logic        sysclk,
    input  logic        reset,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        spi_cs_INV,
    output logic        spi_miso,
    input  logic [15:0] status_in,
    output logic [7:0]  ctrl_out,
    output logic [7:0]  strobe_out,
    output logic        busy
);

    localparam logic [3:0] LAST_CMD_BIT   = 4'(FRAME_BITS / 2 - 1);
    localparam logic [3:0] FIRST_DATA_BIT = 4'(FRAME_BITS / 2);
    localparam logic [3:0] LAST_BIT       = 4'(FRAME_BITS - 1);

    // Synchronized pins
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic cs_level, cs_rise, cs_fall;

    spi_sync_edge u_sync_sck (
        .clk   (sysclk),
        .din   (spi_clk),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    spi_sync_edge u_sync_mosi (
        .clk   (sysclk),
        .din   (spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    spi_sync_edge u_sync_cs (
        .clk   (sysclk),
        .din   (spi_cs_INV),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{sck_level, mosi_rise, mosi_fall};

    // Frame state
    state_t     state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_in;
    logic [7:0] cmd;
    logic [7:0] rd_byte;
    logic [7:0] miso_sr;
    logic       busy_q;

    // Registers
    logic [7:0] ctrl_q;
    logic [7:0] scratch_q;
`ifdef CPLD_SPI_STROBE_EN
    logic [7:0] strobe_q;
`endif

    // Byte completed by the current rising SCK edge
    logic [7:0] shift_next;
    always_comb begin
        shift_next = {shift_in[6:0], mosi_level};
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            // A frame cut by reset is dropped until CS deasserts.
            state     <= cs_level ? StIdle : StDone;
            bit_cnt   <= 4'd0;
            shift_in  <= 8'h00;
            cmd       <= 8'h00;
            rd_byte   <= 8'h00;
            miso_sr   <= 8'h00;
            busy_q    <= 1'b0;
            ctrl_q    <= CTRL_RESET;
            scratch_q <= 8'h00;
`ifdef CPLD_SPI_STROBE_EN
            strobe_q  <= 8'h00;
`endif
        end else begin
`ifdef CPLD_SPI_STROBE_EN
            strobe_q <= 8'h00;
`endif
            if (cs_rise) begin
                busy_q <= 1'b0;
            end else if (cs_fall) begin
                busy_q <= 1'b1;
            end

            case (state)
                StIdle: begin
                    if (cs_fall) begin
                        state    <= StCmd;
                        bit_cnt  <= 4'd0;
                        shift_in <= 8'h00;
                        miso_sr  <= SYNC_BYTE;
                    end
                end

                StCmd: begin
                    if (cs_rise) begin
                        state <= StIdle;
                    end else if (sck_rise) begin
                        shift_in <= shift_next;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_CMD_BIT) begin
                            cmd     <= shift_next;
                            // Status is captured here so a change later in
                            // the frame cannot tear the returned byte.
                            rd_byte <= read_mux(shift_next[2:0], status_in,
                                                ctrl_q, scratch_q);
                            state   <= StData;
                        end
                    end else if (sck_fall) begin
                        miso_sr <= {miso_sr[6:0], 1'b0};
                    end
                end

                StData: begin
                    if (cs_rise) begin
                        state <= StIdle;
                    end else if (sck_rise) begin
                        shift_in <= shift_next;
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= StDone;
                            if (cmd[7]) begin
                                case (cmd[2:0])
                                    ADDR_CTRL:    ctrl_q    <= shift_next;
                                    ADDR_SCRATCH: scratch_q <= shift_next;
`ifdef CPLD_SPI_STROBE_EN
                                    ADDR_STROBE:  strobe_q  <= shift_next;
`endif
                                    default: ;
                                endcase
                            end
                        end
                    end else if (sck_fall) begin
                        // Read byte MSB appears on the first falling edge
                        // after the command byte.
                        if (bit_cnt == FIRST_DATA_BIT) begin
                            miso_sr <= rd_byte;
                        end else begin
                            miso_sr <= {miso_sr[6:0], 1'b0};
                        end
                    end
                end

                StDone: begin
                    if (cs_rise) begin
                        state <= StIdle;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        spi_miso = 1'b0;
        if (state == StCmd || (state == StData && !cmd[7])) begin
            spi_miso = miso_sr[7];
        end
    end

    assign ctrl_out = ctrl_q;
    assign busy     = busy_q;

`ifdef CPLD_SPI_STROBE_EN
    assign strobe_out = strobe_q;
`else
    assign strobe_out = 8'h00;
`endif

endmodule

// File: tb/tb_cpld_spi_responder.sv
// tb_cpld_spi_responder
// Directed bench: 5 MHz sysclk, 500 kHz SCK, hand-computed frame responses.
// All pin changes happen on sysclk falling edges so detection latency is exact.

`timescale 1ns/1ps

module tb_cpld_spi_responder;

    localparam int HALF = 1000; // SCK half period in ns

    logic        sysclk = 1'b0;
    logic        reset;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_cs_INV;
    logic        spi_miso;
    logic [15:0] status_in;
    logic [7:0]  ctrl_out;
    logic [7:0]  strobe_out;
    logic        busy;

    always #100 sysclk = ~sysclk;

    cpld_spi_responder dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_cs_INV (spi_cs_INV),
        .spi_miso   (spi_miso),
        .status_in  (status_in),
        .ctrl_out   (ctrl_out),
        .strobe_out (strobe_out),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe pulse monitor
    int strobe_hi_cycles = 0;
    int strobe_81_cycles = 0;
    always @(negedge sysclk) begin
        if (strobe_out != 8'h00) strobe_hi_cycles++;
        if (strobe_out == 8'h81) strobe_81_cycles++;
    end

    logic [7:0]  ctrl_pre, ctrl_post;
    logic        chg_en;
    logic [15:0] chg_val;

    // One SCK bit; ctrl_out sampled 2 and 3 sysclk after the rising edge.
    task automatic sck_bit(input logic b, output logic m, output logic bz);
        spi_mosi = b;
        #(HALF);
        m  = spi_miso;
        bz = busy;
        spi_clk = 1'b1;
        #400;
        ctrl_pre = ctrl_out;
        #200;
        ctrl_post = ctrl_out;
        #(HALF - 600);
        spi_clk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data,
                             input int nbits, output logic [15:0] rx,
                             output logic busy_all);
        logic [15:0] tx;
        logic        m, bz;
        tx = {cmd, data};
        rx = 16'h0000;
        busy_all = 1'b1;
        @(negedge sysclk);
        spi_cs_INV = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            sck_bit(tx[15-i], m, bz);
            rx[15-i] = m;
            busy_all &= bz;
            if (i == 7 && chg_en) begin
                status_in = chg_val;
                chg_en    = 1'b0;
            end
        end
        #(HALF);
        spi_cs_INV = 1'b1;
        #(4 * HALF);
    endtask

    logic [15:0] rx;
    logic        ball;
    logic        m, bz, m_or;
    logic [15:0] tx;
    int          s_hi, s_81;

    initial begin
        reset      = 1'b1;
        spi_clk    = 1'b0;
        spi_mosi   = 1'b0;
        spi_cs_INV = 1'b1;
        status_in  = 16'h0000;
        chg_en     = 1'b0;
        chg_val    = 16'h0000;
        repeat (6) @(negedge sysclk);
        reset = 1'b0;
        repeat (2) @(negedge sysclk);

        check_val("reset_ctrl", ctrl_out, 8'h00);
        check_val("reset_miso", spi_miso, 1'b0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_strobe", strobe_out, 8'h00);

        // Read ID
        spi_frame(8'h00, 8'h00, 16, rx, ball);
        check_val("read_id", rx, 16'h5AC5);
        check_val("busy_in_frame", ball, 1'b1);
        check_val("busy_after", busy, 1'b0);

        // Write control, check commit timing, read back
        spi_frame(8'h83, 8'h3C, 16, rx, ball);
        check_val("write_ctrl_miso", rx, 16'h5A00);
        check_val("ctrl_before_commit", ctrl_pre, 8'h00);
        check_val("ctrl_at_commit", ctrl_post, 8'h3C);
        spi_frame(8'h03, 8'h00, 16, rx, ball);
        check_val("read_ctrl", rx, 16'h5A3C);

        // Aborted scratch write, then a normal one
        spi_frame(8'h84, 8'hFF, 12, rx, ball);
        spi_frame(8'h04, 8'h00, 16, rx, ball);
        check_val("scratch_after_abort", rx, 16'h5A00);
        spi_frame(8'h84, 8'h77, 16, rx, ball);
        spi_frame(8'h04, 8'h00, 16, rx, ball);
        check_val("scratch_write", rx, 16'h5A77);

        // Status bytes
        status_in = 16'hA55A;
        spi_frame(8'h01, 8'h00, 16, rx, ball);
        check_val("status_lo", rx, 16'h5A5A);
        spi_frame(8'h02, 8'h00, 16, rx, ball);
        check_val("status_hi", rx, 16'h5AA5);
        chg_val = 16'h1234;
        chg_en  = 1'b1;
        spi_frame(8'h01, 8'h00, 16, rx, ball);
        check_val("status_snapshot", rx, 16'h5A5A);
        spi_frame(8'h01, 8'h00, 16, rx, ball);
        check_val("status_new", rx, 16'h5A34);

        // Reset mid-frame with CS low
        tx = {8'h83, 8'hFF};
        @(negedge sysclk);
        spi_cs_INV = 1'b0;
        #(HALF);
        for (int i = 0; i < 4; i++) sck_bit(tx[15-i], m, bz);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        check_val("midreset_ctrl", ctrl_out, 8'h00);
        check_val("midreset_miso", spi_miso, 1'b0);
        check_val("midreset_busy", busy, 1'b0);
        m_or = 1'b0;
        for (int i = 4; i < 16; i++) begin
            sck_bit(tx[15-i], m, bz);
            m_or |= m;
        end
        check_val("ignored_miso", m_or, 1'b0);
        check_val("ignored_ctrl", ctrl_out, 8'h00);
        #(HALF);
        spi_cs_INV = 1'b1;
        #(4 * HALF);
        spi_frame(8'h03, 8'h00, 16, rx, ball);
        check_val("read_after_reset", rx, 16'h5A00);

        // Strobe register
        s_hi = strobe_hi_cycles;
        s_81 = strobe_81_cycles;
        spi_frame(8'h85, 8'h81, 16, rx, ball);
`ifdef CPLD_SPI_STROBE_EN
        check_val("strobe_pulse_len", strobe_hi_cycles - s_hi, 1);
        check_val("strobe_value", strobe_81_cycles - s_81, 1);
`else
        check_val("strobe_tied_low", strobe_hi_cycles - s_hi, 0);
`endif
        check_val("strobe_idle", strobe_out, 8'h00);
        check_val("strobe_ctrl_kept", ctrl_out, 8'h00);
        spi_frame(8'h05, 8'h00, 16, rx, ball);
        check_val("read_strobe", rx, 16'h5A00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #20_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
